// File: rtl/data_ram_pkg.sv
// -----------------------------------------------------------------------------
// data_ram_pkg
// Shared constants for the two-requester data_ram arbiter.
//   AW_DEF / DW_DEF / BW_DEF : default word-address, data and byte-enable widths
//   M0 / M1                  : requester indices into req/gnt vectors
//   SEL_M0 / SEL_M1          : one-bit encodings used for the round-robin
//                              pointer and for tagging an outstanding read
// -----------------------------------------------------------------------------
package data_ram_pkg;

    localparam int AW_DEF = 8;
    localparam int DW_DEF = 32;
    localparam int BW_DEF = DW_DEF / 8;

    localparam int NUM_REQ = 2;
    localparam int M0      = 0;
    localparam int M1      = 1;

    localparam logic [0:0] SEL_M0 = 1'b0;
    localparam logic [0:0] SEL_M1 = 1'b1;

endpackage : data_ram_pkg

// File: rtl/rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin arbiter with a one-bit priority pointer.
//   clk        : clock, pointer updates on rising edge
//   resetn     : asynchronous active-low reset, pointer -> requester 0
//   req[1:0]   : request vector, index M0/M1
//   gnt[1:0]   : one-hot (or zero) grant, combinational from req and pointer
// The pointer always moves to the requester that did not win, so a request
// that loses once is guaranteed to win on the following cycle.
// -----------------------------------------------------------------------------
module rr_arb2
    import data_ram_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic [0:0] prio_q;
    logic [0:0] prio_d;

    // NOTE: every signal assigned in always_comb receives a default at the top
    // of the block, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        gnt    = 2'b00;
        prio_d = prio_q;

        // Grants are suppressed while reset is asserted so the shared RAM port
        // sees no access during reset.
        if (resetn) begin
            if (req[M0] && (!req[M1] || prio_q == SEL_M0)) begin
                gnt[M0] = 1'b1;
            end else if (req[M1]) begin
                gnt[M1] = 1'b1;
            end
        end

        if (gnt[M0]) begin
            prio_d = SEL_M1;
        end else if (gnt[M1]) begin
            prio_d = SEL_M0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its inputs regardless of block ordering.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            prio_q <= SEL_M0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule : rr_arb2

// File: rtl/data_ram_arbiter.sv
// -----------------------------------------------------------------------------
// data_ram_arbiter
// Shares one synchronous data_ram port between two requesters, one access per
// cycle, round-robin on contention.
//   clk, resetn                 : clock, asynchronous active-low reset
//   mX_req/we/addr/wdata        : requester X access (we == 0 means read)
//   mX_gnt                      : access accepted this cycle (combinational)
//   mX_rvalid / mX_rdata        : read response one cycle after a granted read
//   ram_we/ram_addr/ram_din     : muxed winner access to the RAM, zero when idle
//   ram_dout                    : RAM read data, valid the cycle after address
// Writes finish at grant. A granted read is tagged with its owner and the tag
// is registered; the RAM's one-cycle read latency lines up with that tag, so
// rdata is simply ram_dout fanned out to both requesters.
// -----------------------------------------------------------------------------
module data_ram_arbiter
    import data_ram_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF,
    parameter int BW = BW_DEF
) (
    input  logic          clk,
    input  logic          resetn,

    input  logic          m0_req,
    input  logic [BW-1:0] m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,

    input  logic          m1_req,
    input  logic [BW-1:0] m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,

    output logic [BW-1:0] ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
);

    logic [1:0] req;
    logic [1:0] gnt;

    logic       rd_issue;
    logic       rd_pending_q;
    logic       rd_pending_d;
    logic [0:0] rd_owner_q;
    logic [0:0] rd_owner_d;

    assign req = {m1_req, m0_req};

    rr_arb2 u_rr_arb2 (
        .clk    (clk),
        .resetn (resetn),
        .req    (req),
        .gnt    (gnt)
    );

    assign m0_gnt = gnt[M0];
    assign m1_gnt = gnt[M1];

    // Winner mux onto the RAM port; an idle cycle drives all zeros.
    always_comb begin
        ram_we   = '0;
        ram_addr = '0;
        ram_din  = '0;
        rd_issue = 1'b0;

        if (gnt[M0]) begin
            ram_we   = m0_we;
            ram_addr = m0_addr;
            ram_din  = m0_wdata;
            rd_issue = (m0_we == '0);
        end else if (gnt[M1]) begin
            ram_we   = m1_we;
            ram_addr = m1_addr;
            ram_din  = m1_wdata;
            rd_issue = (m1_we == '0);
        end

        rd_pending_d = rd_issue;
        rd_owner_d   = gnt[M1] ? SEL_M1 : SEL_M0;
    end

    // Response tag: one entry deep because a new access can start every cycle
    // and each read answers exactly one cycle later.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_pending_q <= 1'b0;
            rd_owner_q   <= SEL_M0;
        end else begin
            rd_pending_q <= rd_pending_d;
            rd_owner_q   <= rd_owner_d;
        end
    end

    assign m0_rvalid = rd_pending_q && (rd_owner_q == SEL_M0);
    assign m1_rvalid = rd_pending_q && (rd_owner_q == SEL_M1);

    assign m0_rdata  = ram_dout;
    assign m1_rdata  = ram_dout;

endmodule : data_ram_arbiter

// File: tb/tb_data_ram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_data_ram_arbiter
// Drives data_ram_arbiter against a behavioural synchronous RAM. A bench-side
// round-robin model predicts grants and the RAM mux every cycle; granted reads
// push {owner, expected data} from a reference memory onto a queue that is
// popped on the following cycle and compared with rvalid/rdata.
// -----------------------------------------------------------------------------
module tb_data_ram_arbiter;
    import data_ram_pkg::*;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int BW = 4;

    logic          clk;
    logic          resetn;
    logic          m0_req,    m1_req;
    logic [BW-1:0] m0_we,     m1_we;
    logic [AW-1:0] m0_addr,   m1_addr;
    logic [DW-1:0] m0_wdata,  m1_wdata;
    logic          m0_gnt,    m1_gnt;
    logic          m0_rvalid, m1_rvalid;
    logic [DW-1:0] m0_rdata,  m1_rdata;
    logic [BW-1:0] ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;

    data_ram_arbiter #(.AW(AW), .DW(DW), .BW(BW)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .m0_req    (m0_req),
        .m0_we     (m0_we),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m0_gnt    (m0_gnt),
        .m0_rvalid (m0_rvalid),
        .m0_rdata  (m0_rdata),
        .m1_req    (m1_req),
        .m1_we     (m1_we),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_gnt    (m1_gnt),
        .m1_rvalid (m1_rvalid),
        .m1_rdata  (m1_rdata),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural data_ram: registered read, byte-enable write.
    bit [DW-1:0] ram_mem [256];

    always @(posedge clk) begin : ram_model
        logic [DW-1:0] cur;
        cur = ram_mem[ram_addr];
        ram_dout <= cur;
        if (ram_we != '0) begin
            for (int b = 0; b < BW; b++) begin
                if (ram_we[b]) cur[8*b +: 8] = ram_din[8*b +: 8];
            end
            ram_mem[ram_addr] <= cur;
        end
    end

    // Scoreboard state
    typedef struct {
        bit            owner;
        logic [DW-1:0] data;
    } rd_exp_t;

    rd_exp_t       exp_q [$];
    logic [DW-1:0] ref_mem [int];
    bit            prio_m;
    int            wait0, wait1;
    bit            last_g0, last_g1;
    int            n_tests;
    int            n_fail;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : '0;
    endfunction

    // Sampled at the falling edge: responses first, then this cycle's grant.
    task automatic do_checks();
        rd_exp_t       e;
        bit            g0, g1;
        logic [BW-1:0] xwe;
        logic [AW-1:0] xaddr;
        logic [DW-1:0] xdin;
        logic [DW-1:0] cur;

        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("m0_rvalid", m0_rvalid, e.owner == 1'b0);
            check("m1_rvalid", m1_rvalid, e.owner == 1'b1);
            if (e.owner == 1'b0) check("m0_rdata", m0_rdata, e.data);
            else                 check("m1_rdata", m1_rdata, e.data);
        end else begin
            check("m0_rvalid_idle", m0_rvalid, 0);
            check("m1_rvalid_idle", m1_rvalid, 0);
        end

        g0 = m0_req && (!m1_req || prio_m == 1'b0);
        g1 = m1_req && !g0;
        check("m0_gnt", m0_gnt, g0);
        check("m1_gnt", m1_gnt, g1);
        check("one_gnt", m0_gnt && m1_gnt, 0);

        xwe = '0; xaddr = '0; xdin = '0;
        if (g0)      begin xwe = m0_we; xaddr = m0_addr; xdin = m0_wdata; end
        else if (g1) begin xwe = m1_we; xaddr = m1_addr; xdin = m1_wdata; end
        check("ram_we",   ram_we,   xwe);
        check("ram_addr", ram_addr, xaddr);
        check("ram_din",  ram_din,  xdin);

        if (m0_req && !m0_gnt) wait0++; else wait0 = 0;
        if (m1_req && !m1_gnt) wait1++; else wait1 = 0;
        if (m0_req) check("m0_wait", wait0 <= 1, 1);
        if (m1_req) check("m1_wait", wait1 <= 1, 1);

        if (g0 || g1) begin
            prio_m = g0;
            if (xwe == '0) begin
                e.owner = g1;
                e.data  = ref_read(xaddr);
                exp_q.push_back(e);
            end else begin
                cur = ref_read(xaddr);
                for (int b = 0; b < BW; b++) begin
                    if (xwe[b]) cur[8*b +: 8] = xdin[8*b +: 8];
                end
                ref_mem[int'(xaddr)] = cur;
            end
        end
        last_g0 = g0;
        last_g1 = g1;
    endtask

    task automatic cycle();
        @(negedge clk);
        do_checks();
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(input logic r, input logic [BW-1:0] we,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
        m0_req = r; m0_we = we; m0_addr = a; m0_wdata = d;
    endtask

    task automatic drive1(input logic r, input logic [BW-1:0] we,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
        m1_req = r; m1_we = we; m1_addr = a; m1_wdata = d;
    endtask

    task automatic idle();
        drive0(1'b0, '0, '0, '0);
        drive1(1'b0, '0, '0, '0);
    endtask

    // Asserts reset with both requesters active, checks the port is quiet,
    // and releases just after a rising edge.
    task automatic apply_reset();
        resetn = 1'b0;
        exp_q.delete();
        prio_m = 1'b0;
        wait0  = 0;
        wait1  = 0;
        drive0(1'b1, '0, 8'h01, '0);
        drive1(1'b1, '1, 8'h02, 32'h5555_AAAA);
        #1;
        check("rst_m0_gnt",    m0_gnt,    0);
        check("rst_m1_gnt",    m1_gnt,    0);
        check("rst_ram_we",    ram_we,    0);
        check("rst_m0_rvalid", m0_rvalid, 0);
        check("rst_m1_rvalid", m1_rvalid, 0);
        @(posedge clk);
        #1;
        check("rst_hold_gnt",    {m1_gnt, m0_gnt},       0);
        check("rst_hold_rvalid", {m1_rvalid, m0_rvalid}, 0);
        idle();
        resetn = 1'b1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        resetn  = 1'b1;
        idle();
        #2;
        apply_reset();

        // Write then read back the same word from m0.
        drive0(1'b1, 4'hF, 8'h05, 32'hDEAD_BEEF); cycle();
        drive0(1'b1, 4'h0, 8'h05, 32'h0);         cycle();
        idle();                                   cycle();
        idle();                                   cycle();

        // Continuous contention from reset: grants alternate m0, m1, ...
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            drive0(1'b1, 4'h0, 8'h10, '0);
            drive1(1'b1, 4'h0, 8'h20, '0);
            cycle();
        end
        idle(); cycle();

        // Full write by m1, partial write by m0, read back by m1.
        drive1(1'b1, 4'hF,    8'h07, 32'h1122_3344); cycle();
        idle();
        drive0(1'b1, 4'b0011, 8'h07, 32'hAAAA_BBBB); cycle();
        idle();
        drive1(1'b1, 4'h0,    8'h07, 32'h0);         cycle();
        idle();                                      cycle();

        // Only m1 for five cycles, then both: m0 must win first.
        for (int i = 0; i < 5; i++) begin
            drive1(1'b1, 4'h0, 8'(8'h30 + i), '0);
            cycle();
        end
        drive0(1'b1, 4'h0, 8'h10, '0);
        drive1(1'b1, 4'h0, 8'h20, '0);
        cycle();
        cycle();
        idle(); cycle();

        // Reset pulse while an m0 read is outstanding.
        drive0(1'b1, 4'h0, 8'h05, '0);
        @(negedge clk);
        do_checks();
        #2;
        resetn = 1'b0;
        exp_q.delete();
        prio_m = 1'b0;
        wait0  = 0;
        wait1  = 0;
        #1;
        check("rstpulse_m0_gnt", m0_gnt, 0);
        check("rstpulse_ram_we", ram_we, 0);
        @(posedge clk);
        #1;
        check("rstpulse_m0_rvalid", m0_rvalid, 0);
        drive0(1'b1, 4'h0, 8'h05, '0);
        drive1(1'b1, 4'h0, 8'h07, '0);
        resetn = 1'b1;
        cycle();
        idle(); cycle();
        idle(); cycle();

        // Random traffic; a pending request is normally held until granted.
        for (int c = 0; c < 10000; c++) begin
            if (!(m0_req && !last_g0 && $urandom_range(15) != 0)) begin
                drive0(1'($urandom_range(1)),
                       $urandom_range(1) ? BW'($urandom) : '0,
                       AW'($urandom_range(15)), $urandom);
            end
            if (!(m1_req && !last_g1 && $urandom_range(15) != 0)) begin
                drive1(1'($urandom_range(1)),
                       $urandom_range(1) ? BW'($urandom) : '0,
                       AW'($urandom_range(15)), $urandom);
            end
            cycle();
        end
        idle(); cycle();
        idle(); cycle();
        check("drain", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_data_ram_arbiter
